// File: rtl/mux_n_stream_rr.sv
// N-channel stream mux (external select or round-robin) with a registered output, 1-cycle latency.
// Under back-pressure the output word is held and no input is accepted; no skid buffer.
module mux_n_stream_rr #(
   parameter int SIZE     = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CHANNELS*SIZE-1:0] data_in,
   input  logic [CHANNELS-1:0]      valid_in,
   output logic [CHANNELS-1:0]      ready_in,
   input  logic [SEL_W-1:0]         sel_in,
   input  logic                     mode_rr,
   output logic [SIZE-1:0]          data_out,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [SEL_W-1:0]         grant_out
);

   // Resetting last_grant to the top channel makes the first round-robin search begin at 0.
   localparam logic [SEL_W-1:0] LAST_GRANT_RST = SEL_W'(CHANNELS - 1);

   logic [SIZE-1:0]  data_q, data_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] last_grant_q, last_grant_d;

   logic             load_en;
   logic             sel_ok;
   logic             hi_found, lo_found;
   logic [SEL_W-1:0] hi_idx, lo_idx;
   logic             choice_vld;
   logic [SEL_W-1:0] chosen;
   logic [SIZE-1:0]  chosen_word;

   assign load_en = !valid_q || ready_out;

   always_comb begin
      sel_ok   = 1'b0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (int'(sel_in) == k && valid_in[k]) sel_ok = 1'b1;
      end
      // Descending scan: the last hit is the lowest index above / at-or-below last_grant.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (valid_in[k]) begin
            if (k > int'(last_grant_q)) begin
               hi_found = 1'b1;
               hi_idx   = SEL_W'(k);
            end else begin
               lo_found = 1'b1;
               lo_idx   = SEL_W'(k);
            end
         end
      end
      if (mode_rr) begin
         choice_vld = hi_found || lo_found;
         chosen     = hi_found ? hi_idx : lo_idx;
      end else begin
         choice_vld = sel_ok;
         chosen     = sel_in;
      end
   end

   always_comb begin
      chosen_word = '0;
      ready_in    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (int'(chosen) == k) begin
            chosen_word = data_in[k*SIZE +: SIZE];
            ready_in[k] = load_en && choice_vld;
         end
      end
   end

   always_comb begin
      data_d       = data_q;
      valid_d      = valid_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      if (load_en) begin
         valid_d = choice_vld;
         if (choice_vld) begin
            data_d       = chosen_word;
            grant_d      = chosen;
            last_grant_d = chosen;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q       <= '0;
         valid_q      <= 1'b0;
         grant_q      <= '0;
         last_grant_q <= LAST_GRANT_RST;
      end else begin
         data_q       <= data_d;
         valid_q      <= valid_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign grant_out = grant_q;

endmodule

// File: tb/tb_mux_n_stream_rr.sv
// Directed bench for mux_n_stream_rr: a 4-channel instance plus a 3-channel one for out-of-range select.
module tb_mux_n_stream_rr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] data_in_a;
   logic [3:0]  valid_in_a;
   logic [3:0]  ready_in_a;
   logic [1:0]  sel_in_a;
   logic        mode_rr_a;
   logic [7:0]  data_out_a;
   logic        valid_out_a;
   logic        ready_out_a;
   logic [1:0]  grant_out_a;

   logic [23:0] data_in_b;
   logic [2:0]  valid_in_b;
   logic [2:0]  ready_in_b;
   logic [1:0]  sel_in_b;
   logic        mode_rr_b;
   logic [7:0]  data_out_b;
   logic        valid_out_b;
   logic        ready_out_b;
   logic [1:0]  grant_out_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_n_stream_rr #(.SIZE(8), .CHANNELS(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst(rst),
      .data_in(data_in_a), .valid_in(valid_in_a), .ready_in(ready_in_a),
      .sel_in(sel_in_a), .mode_rr(mode_rr_a),
      .data_out(data_out_a), .valid_out(valid_out_a), .ready_out(ready_out_a),
      .grant_out(grant_out_a)
   );

   mux_n_stream_rr #(.SIZE(8), .CHANNELS(3), .SEL_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .data_in(data_in_b), .valid_in(valid_in_b), .ready_in(ready_in_b),
      .sel_in(sel_in_b), .mode_rr(mode_rr_b),
      .data_out(data_out_b), .valid_out(valid_out_b), .ready_out(ready_out_b),
      .grant_out(grant_out_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Reset asserted from time 0
      #2;
      n_checks++;
      if (data_out_a !== 8'h00 || valid_out_a !== 1'b0 || grant_out_a !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_initial: data=%h valid=%b grant=%0d, want 00/0/0", data_out_a, valid_out_a, grant_out_a);
      end
      step();
      rst = 1'b0;
      // Load one word so a transfer is in flight
      mode_rr_a = 1'b0; sel_in_a = 2'd3; valid_in_a = 4'b1111; ready_out_a = 1'b0;
      step();
      n_checks++;
      if (valid_out_a !== 1'b1 || data_out_a !== 8'h44) begin
         n_fail++;
         $display("FAIL reset_preload: data=%h valid=%b, want 44/1", data_out_a, valid_out_a);
      end
      // Asynchronous assertion away from any clock edge
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (data_out_a !== 8'h00 || valid_out_a !== 1'b0 || grant_out_a !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_async: data=%h valid=%b grant=%0d, want 00/0/0", data_out_a, valid_out_a, grant_out_a);
      end
      step();
      rst = 1'b0;
      mode_rr_a = 1'b1; ready_out_a = 1'b1;
      #1;
      n_checks++;
      if (ready_in_a !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_rr_first_ready: ready_in=%b, want 0001", ready_in_a);
      end
      step();
      n_checks++;
      if (grant_out_a !== 2'd0 || data_out_a !== 8'h11 || valid_out_a !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rr_first_grant: grant=%0d data=%h valid=%b, want 0/11/1", grant_out_a, data_out_a, valid_out_a);
      end
   endtask

   task automatic test_select();
      mode_rr_a = 1'b0; sel_in_a = 2'd2; valid_in_a = 4'b1111; ready_out_a = 1'b1;
      #1;
      n_checks++;
      if (ready_in_a !== 4'b0100) begin
         n_fail++;
         $display("FAIL select_ready: ready_in=%b, want 0100", ready_in_a);
      end
      step();
      n_checks++;
      if (data_out_a !== 8'h33 || grant_out_a !== 2'd2 || valid_out_a !== 1'b1) begin
         n_fail++;
         $display("FAIL select_load: data=%h grant=%0d valid=%b, want 33/2/1", data_out_a, grant_out_a, valid_out_a);
      end
   endtask

   task automatic test_backpressure();
      ready_out_a = 1'b0; sel_in_a = 2'd1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (ready_in_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_ready_%0d: ready_in=%b, want 0000", i, ready_in_a);
         end
         step();
         n_checks++;
         if (data_out_a !== 8'h33 || valid_out_a !== 1'b1 || grant_out_a !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: data=%h valid=%b grant=%0d, want 33/1/2", i, data_out_a, valid_out_a, grant_out_a);
         end
      end
      ready_out_a = 1'b1;
      #1;
      n_checks++;
      if (ready_in_a !== 4'b0010) begin
         n_fail++;
         $display("FAIL stall_release_ready: ready_in=%b, want 0010", ready_in_a);
      end
      step();
      n_checks++;
      if (data_out_a !== 8'h22 || valid_out_a !== 1'b1 || grant_out_a !== 2'd1) begin
         n_fail++;
         $display("FAIL stall_release_load: data=%h valid=%b grant=%0d, want 22/1/1", data_out_a, valid_out_a, grant_out_a);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_word [4];
      logic [1:0] exp_g;
      exp_word = '{8'h11, 8'h22, 8'h33, 8'h44};
      // Park last_grant on ch3 so the round-robin sequence starts at ch0
      mode_rr_a = 1'b0; sel_in_a = 2'd3; valid_in_a = 4'b1111; ready_out_a = 1'b1;
      step();
      mode_rr_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_g = 2'(i % 4);
         #1;
         n_checks++;
         if (ready_in_a !== (4'b0001 << exp_g) || $countones(ready_in_a) != 1) begin
            n_fail++;
            $display("FAIL rr_ready_%0d: ready_in=%b, want %b", i, ready_in_a, 4'b0001 << exp_g);
         end
         step();
         n_checks++;
         if (grant_out_a !== exp_g || data_out_a !== exp_word[exp_g] || valid_out_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: grant=%0d data=%h valid=%b, want %0d/%h/1", i, grant_out_a, data_out_a, valid_out_a, exp_g, exp_word[exp_g]);
         end
      end
   endtask

   task automatic test_rr_wrap();
      mode_rr_a = 1'b0; sel_in_a = 2'd2; valid_in_a = 4'b1111; ready_out_a = 1'b1;
      step();
      mode_rr_a = 1'b1; valid_in_a = 4'b0011;
      #1;
      n_checks++;
      if (ready_in_a !== 4'b0001) begin
         n_fail++;
         $display("FAIL rr_wrap_ready: ready_in=%b, want 0001", ready_in_a);
      end
      step();
      n_checks++;
      if (grant_out_a !== 2'd0 || data_out_a !== 8'h11) begin
         n_fail++;
         $display("FAIL rr_wrap_grant: grant=%0d data=%h, want 0/11", grant_out_a, data_out_a);
      end
      valid_in_a = 4'b0000;
      #1;
      n_checks++;
      if (ready_in_a !== 4'b0000) begin
         n_fail++;
         $display("FAIL rr_empty_ready: ready_in=%b, want 0000", ready_in_a);
      end
      step();
      n_checks++;
      if (valid_out_a !== 1'b0 || data_out_a !== 8'h11 || grant_out_a !== 2'd0) begin
         n_fail++;
         $display("FAIL rr_empty_drain: valid=%b data=%h grant=%0d, want 0/11/0", valid_out_a, data_out_a, grant_out_a);
      end
   endtask

   task automatic test_out_of_range();
      mode_rr_b = 1'b0; sel_in_b = 2'd1; valid_in_b = 3'b111; ready_out_b = 1'b1;
      step();
      n_checks++;
      if (data_out_b !== 8'hBB || valid_out_b !== 1'b1 || grant_out_b !== 2'd1) begin
         n_fail++;
         $display("FAIL oor_preload: data=%h valid=%b grant=%0d, want BB/1/1", data_out_b, valid_out_b, grant_out_b);
      end
      sel_in_b = 2'd3;
      #1;
      n_checks++;
      if (ready_in_b !== 3'b000) begin
         n_fail++;
         $display("FAIL oor_ready: ready_in=%b, want 000", ready_in_b);
      end
      step();
      n_checks++;
      if (valid_out_b !== 1'b0 || data_out_b !== 8'hBB || grant_out_b !== 2'd1) begin
         n_fail++;
         $display("FAIL oor_drain: valid=%b data=%h grant=%0d, want 0/BB/1", valid_out_b, data_out_b, grant_out_b);
      end
   endtask

   initial begin
      data_in_a   = {8'h44, 8'h33, 8'h22, 8'h11};
      valid_in_a  = 4'b0000;
      sel_in_a    = 2'd0;
      mode_rr_a   = 1'b0;
      ready_out_a = 1'b0;
      data_in_b   = {8'hCC, 8'hBB, 8'hAA};
      valid_in_b  = 3'b000;
      sel_in_b    = 2'd0;
      mode_rr_b   = 1'b0;
      ready_out_b = 1'b0;

      test_reset();
      test_select();
      test_backpressure();
      test_round_robin();
      test_rr_wrap();
      test_out_of_range();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
